// File: rtl/io_uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package io_uart_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned BUS_W  = 32;
   localparam int unsigned DIV_W  = 16;
   localparam int unsigned BIDX_W = 3;

   // Register word indices relative to the block base address
   localparam logic [5:0] REG_TXDATA = 6'd0;
   localparam logic [5:0] REG_STATUS = 6'd1;
   localparam logic [5:0] REG_DIV    = 6'd2;

   // STATUS register bit positions
   localparam int unsigned STAT_EMPTY   = 0;
   localparam int unsigned STAT_FULL    = 1;
   localparam int unsigned STAT_OVF     = 2;
   localparam int unsigned STAT_ACTIVE  = 3;
   localparam int unsigned STAT_CNT_LSB = 4;
   localparam int unsigned STAT_CNT_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/io_uart_tx_sync_fifo8.sv
// Byte-wide synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo8
   import io_uart_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              clrn,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok;
   logic              pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   // Pointer and occupancy update; pointers wrap naturally at a power-of-two depth
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register
   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array, written only on an accepted push
   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, divisor/overflow registers, TX FSM and baud counter.
module io_uart_tx
   import io_uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  BASE_ADDR  = 8'hC0
) (
   input  logic             clock,
   input  logic             clrn,
   input  logic [BUS_W-1:0] addr,
   input  logic [BUS_W-1:0] datas,
   input  logic             we,
   output logic [BUS_W-1:0] dataout,
   output logic             txd,
   output logic             tx_busy
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   tx_state_e         state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  bitlen_q, bitlen_d;
   logic [DIV_W-1:0]  baud_q, baud_d;
   logic [BIDX_W-1:0] bit_idx_q, bit_idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              txd_q, txd_d;
   logic              ovf_q, ovf_d;

   logic [5:0]        word_off;
   logic              sel_tx, sel_status, sel_div;
   logic              push, pop, push_drop, bit_end, tx_active;
   logic [DATA_W-1:0] fifo_rdata;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [BUS_W-1:0]  status_rd;
   logic              unused_bits;

   assign unused_bits = ^{addr[BUS_W-1:8], addr[1:0], datas[BUS_W-1:DIV_W]};

   // Address decode on the low byte; the block lives in the upper half of I/O space
   assign word_off   = addr[7:2] - BASE_ADDR[7:2];
   assign sel_tx     = addr[7] && (word_off == REG_TXDATA);
   assign sel_status = addr[7] && (word_off == REG_STATUS);
   assign sel_div    = addr[7] && (word_off == REG_DIV);

   assign push      = we & sel_tx;
   assign push_drop = push & fifo_full & ~pop;
   assign bit_end   = (baud_q == '0);
   assign tx_active = (state_q != ST_IDLE);
   assign tx_busy   = tx_active | ~fifo_empty;
   assign txd       = txd_q;

   sync_fifo8 #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clock   (clock),
      .clrn    (clrn),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (datas[DATA_W-1:0]),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   // Read mux: STATUS and DIV are readable, everything else reads zero
   always_comb begin
      status_rd                                = '0;
      status_rd[STAT_EMPTY]                    = fifo_empty;
      status_rd[STAT_FULL]                     = fifo_full;
      status_rd[STAT_OVF]                      = ovf_q;
      status_rd[STAT_ACTIVE]                   = tx_active;
      status_rd[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_cnt);
      dataout = '0;
      if (sel_status)   dataout = status_rd;
      else if (sel_div) dataout = BUS_W'(div_q);
   end

   // Divisor and sticky overflow; a zero divisor is stored as 1
   always_comb begin
      div_d = div_q;
      ovf_d = ovf_q;
      if (we && sel_div) div_d = (datas[DIV_W-1:0] == '0) ? DIV_W'(1) : datas[DIV_W-1:0];
      if (we && sel_status && datas[STAT_OVF]) ovf_d = 1'b0;
      if (push_drop) ovf_d = 1'b1;
   end

   // Frame sequencer: next state, baud counter, shifter and registered serial level
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bitlen_d  = bitlen_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      txd_d     = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               shift_d  = fifo_rdata;
               bitlen_d = div_q;
               baud_d   = div_q - DIV_W'(1);
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               baud_d    = bitlen_q - DIV_W'(1);
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end else begin
               baud_d = baud_q - DIV_W'(1);
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               baud_d = bitlen_q - DIV_W'(1);
               if (bit_idx_q == BIDX_W'(DATA_W - 1)) begin
                  state_d = ST_STOP;
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_idx_d = bit_idx_q + BIDX_W'(1);
               end
            end else begin
               baud_d = baud_q - DIV_W'(1);
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  shift_d  = fifo_rdata;
                  bitlen_d = div_q;
                  baud_d   = div_q - DIV_W'(1);
                  state_d  = ST_START;
               end else begin
                  baud_d    = '0;
                  bit_idx_d = '0;
                  state_d   = ST_IDLE;
               end
            end else begin
               baud_d = baud_q - DIV_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shift_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         state_q   <= ST_IDLE;
         div_q     <= DIV_W'(CLK_DIV);
         bitlen_q  <= DIV_W'(CLK_DIV);
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bitlen_q  <= bitlen_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: register table plus hand-built frame sequences.
module tb_io_uart_tx;

   logic        clock;
   logic        clrn;
   logic [31:0] addr;
   logic [31:0] datas;
   logic        we;
   logic [31:0] dataout;
   logic        txd;
   logic        tx_busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   localparam logic [31:0] A_TX  = 32'hC0;
   localparam logic [31:0] A_ST  = 32'hC4;
   localparam logic [31:0] A_DIV = 32'hC8;

   io_uart_tx #(.CLK_DIV(16), .FIFO_DEPTH(4), .BASE_ADDR(8'hC0)) dut (
      .clock   (clock),
      .clrn    (clrn),
      .addr    (addr),
      .datas   (datas),
      .we      (we),
      .dataout (dataout),
      .txd     (txd),
      .tx_busy (tx_busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time limit, expected finish");
      $fatal(1, "time limit reached");
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clock);
      addr  = a;
      datas = d;
      we    = 1'b1;
      @(negedge clock);
      we    = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(name, dataout, exp);
   endtask

   // Samples txd on each negedge from frame clock start_k to the end of the frame
   task automatic check_frame(input logic [7:0] b, input int div, input int start_k, input string name);
      logic e;
      logic bad_txd;
      logic bad_busy;
      int   bi;
      int   bad_k;
      logic ok;
      ok    = 1'b1;
      bad_k = -1;
      bad_txd  = 1'b0;
      bad_busy = 1'b0;
      for (int k = start_k; k < 10 * div; k++) begin
         @(negedge clock);
         bi = k / div;
         if (bi == 0)      e = 1'b0;
         else if (bi == 9) e = 1'b1;
         else              e = b[bi-1];
         if (ok && (txd !== e || tx_busy !== 1'b1)) begin
            ok       = 1'b0;
            bad_k    = k;
            bad_txd  = txd;
            bad_busy = tx_busy;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: at frame clock %0d txd=%0b busy=%0b, expected txd per 8N1 of 0x%0h and busy=1",
                  name, bad_k, bad_txd, bad_busy, b);
      end
   endtask

   initial begin
      int   t0;
      logic quiet;

      vecs[0]  = '{1'b0, 32'hC4,       32'h0,       32'h1};
      vecs[1]  = '{1'b0, 32'hC8,       32'h0,       32'h10};
      vecs[2]  = '{1'b0, 32'hC0,       32'h0,       32'h0};
      vecs[3]  = '{1'b0, 32'hCC,       32'h0,       32'h0};
      vecs[4]  = '{1'b0, 32'h48,       32'h0,       32'h0};
      vecs[5]  = '{1'b1, 32'hC8,       32'h4,       32'h4};
      vecs[6]  = '{1'b1, 32'hC8,       32'h0,       32'h1};
      vecs[7]  = '{1'b1, 32'hC8,       32'h12345,   32'h2345};
      vecs[8]  = '{1'b1, 32'hCC,       32'h5,       32'h0};
      vecs[9]  = '{1'b0, 32'hC8,       32'h0,       32'h2345};
      vecs[10] = '{1'b1, 32'hC4,       32'hFF,      32'h1};
      vecs[11] = '{1'b0, 32'hFFFFFFC8, 32'h0,       32'h2345};
      vecs[12] = '{1'b1, 32'hC8,       32'h4,       32'h4};

      clrn  = 1'b1;
      we    = 1'b0;
      addr  = 32'h0;
      datas = 32'h0;
      #1 clrn = 1'b0;
      repeat (2) @(negedge clock);
      chk("reset_txd", 32'(txd), 32'h1);
      chk("reset_busy", 32'(tx_busy), 32'h0);
      clrn = 1'b1;

      // Register table
      for (int i = 0; i < 13; i++) begin
         if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
         rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      end

      // Single byte 0xA5 at DIV=4
      wr(A_DIV, 32'h4);
      wr(A_TX, 32'hA5);
      chk("a5_pre_txd", 32'(txd), 32'h1);
      chk("a5_pre_busy", 32'(tx_busy), 32'h1);
      check_frame(8'hA5, 4, 0, "a5_frame");
      @(negedge clock);
      chk("a5_post_busy", 32'(tx_busy), 32'h0);
      rd_chk("a5_post_status", A_ST, 32'h01);

      // Back-to-back 0x00, 0xFF at DIV=2
      wr(A_DIV, 32'h2);
      @(negedge clock);
      addr = A_TX; datas = 32'h00; we = 1'b1;
      @(negedge clock);
      datas = 32'hFF;
      @(negedge clock);
      we = 1'b0;
      rd_chk("b2b_status_cnt1", A_ST, 32'h18);
      chk("b2b_start0", 32'(txd), 32'h0);
      check_frame(8'h00, 2, 1, "b2b_frame0");
      @(negedge clock);
      #1;
      chk("b2b_nogap_txd", 32'(txd), 32'h0);
      chk("b2b_status_cnt0", dataout, 32'h09);
      check_frame(8'hFF, 2, 1, "b2b_frame1");
      @(negedge clock);
      #1;
      chk("b2b_post_status", dataout, 32'h01);
      chk("b2b_post_busy", 32'(tx_busy), 32'h0);

      // Divisor 0 stored as 1, then a mid-frame divisor change
      wr(A_DIV, 32'h0);
      rd_chk("div0_reads1", A_DIV, 32'h1);
      wr(A_TX, 32'h55);
      check_frame(8'h55, 1, 0, "div1_frame");
      @(negedge clock);
      chk("div1_post_busy", 32'(tx_busy), 32'h0);
      wr(A_DIV, 32'h2);
      @(negedge clock);
      addr = A_TX; datas = 32'hC3; we = 1'b1;
      @(negedge clock);
      datas = 32'h96;
      @(negedge clock);
      addr = A_DIV; datas = 32'h8;
      @(negedge clock);
      we = 1'b0;
      check_frame(8'hC3, 2, 2, "midwr_old_div");
      check_frame(8'h96, 8, 0, "midwr_new_div");
      @(negedge clock);
      chk("midwr_post_busy", 32'(tx_busy), 32'h0);
      rd_chk("midwr_div8", A_DIV, 32'h8);

      // Overflow at DIV=100, then push/pop on a full FIFO, then reset mid-frame
      wr(A_DIV, 32'd100);
      @(negedge clock);
      addr = A_TX; datas = 32'h11; we = 1'b1;
      @(negedge clock);
      t0 = cyc;
      datas = 32'h20;
      @(negedge clock); datas = 32'h33;
      @(negedge clock); datas = 32'h44;
      @(negedge clock); datas = 32'h55;
      @(negedge clock); datas = 32'h66;
      @(negedge clock);
      we = 1'b0;
      rd_chk("ovf_status", A_ST, 32'h4E);
      wr(A_ST, 32'h04);
      rd_chk("ovf_cleared", A_ST, 32'h4A);
      while (cyc < t0 + 1000) @(negedge clock);
      addr = A_TX; datas = 32'h3C; we = 1'b1;
      @(negedge clock);
      we = 1'b0;
      rd_chk("full_pushpop_status", A_ST, 32'h4A);
      chk("full_pushpop_start", 32'(txd), 32'h0);
      repeat (150) @(negedge clock);
      chk("rst_pre_txd", 32'(txd), 32'h0);
      #2 clrn = 1'b0;
      #1;
      chk("rst_async_txd", 32'(txd), 32'h1);
      chk("rst_async_busy", 32'(tx_busy), 32'h0);
      @(negedge clock);
      clrn = 1'b1;
      rd_chk("rst_div", A_DIV, 32'h10);
      rd_chk("rst_status", A_ST, 32'h01);
      quiet = 1'b1;
      repeat (60) begin
         @(negedge clock);
         if (txd !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
      end
      chk("rst_no_residual", 32'(quiet), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
